rmt_pkt_filter: RTL and testbench
=================================

# rmt_pkt_filter

Ingress classifier placed directly upstream of `rmt_wrapper`. It inspects the first 512-bit beat of every AXI-Stream packet and forwards only VLAN-tagged IPv4/UDP packets, unmodified, to the RMT pipeline. All other packets are consumed and discarded. A one-deep registered output stage keeps `m_axis_*` driven from flops, and full valid/ready backpressure is supported.

## Interface
- `C_S_AXIS_DATA_WIDTH`, 512: data width of both streams.
- `C_S_AXIS_TUSER_WIDTH`, 128: tuser width, passed through unchanged.
- `ETHERTYPE_MATCH`, 16'h0008: required value of tdata[143:128] on the first beat (0x0800, wire byte order).
- `IP_PROTO_MATCH`, 8'h11: required value of tdata[223:216] on the first beat.
- `CNT_WIDTH`, 32: width of the statistics counters.

Ports:
- `clk` in 1: single clock for the block.
- `areset` in 1: synchronous, active-high reset.
- `s_axis_tdata` in 512: ingress data.
- `s_axis_tkeep` in 64: ingress byte enables.
- `s_axis_tuser` in 128: ingress metadata.
- `s_axis_tvalid` in 1: ingress valid.
- `s_axis_tready` out 1: ingress ready.
- `s_axis_tlast` in 1: ingress end of packet.
- `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tuser`, `m_axis_tvalid`, `m_axis_tlast`: out, same widths as ingress; stream to `rmt_wrapper`.
- `m_axis_tready` in 1: ready from `rmt_wrapper`.
- `pass_cnt` out CNT_WIDTH: count of forwarded packets (present only with the stats macro).
- `drop_cnt` out CNT_WIDTH: count of dropped packets (present only with the stats macro).

## Operation
- A beat transfers on ingress when `s_axis_tvalid && s_axis_tready`.
- FSM states:
  - IDLE: awaiting a first beat.
  - FWD: passing the remaining beats of an accepted packet.
  - DROP: discarding the remaining beats of a rejected packet.
- Match condition on a first beat: tdata[143:128]==ETHERTYPE_MATCH, and tdata[223:216]==IP_PROTO_MATCH, and tkeep[27:0] all ones. A beat with any of tkeep[27:0] clear is a runt and is rejected.
- IDLE, first beat transfers:
  - Match: the beat is loaded into the output register. Next state is FWD, or stays IDLE if tlast is set.
  - No match: the beat is discarded. Next state is DROP, or stays IDLE if tlast is set.
- FWD: each beat is loaded into the output register. On tlast, next state is IDLE.
- DROP: each beat is discarded. On tlast, next state is IDLE.
- Forwarded beats are bit-exact copies: tdata, tkeep, tuser and tlast are all preserved.
- Counters:
  - `pass_cnt` increments once per accepted first beat.
  - `drop_cnt` increments once per rejected first beat.
  - Both wrap modulo 2^CNT_WIDTH and never saturate.
- Simultaneous output pop and new load in the same cycle is legal: the register is refilled with no bubble.

## Timing
- Latency: an accepted beat appears on `m_axis_*` in the cycle after it transfers on ingress (1 cycle).
- Throughput: one beat per cycle sustained when `m_axis_tready` is held high.
- `s_axis_tready`:
  - IDLE and FWD: `!m_axis_tvalid || m_axis_tready`.
  - DROP: constant 1.
  - The signal is combinational from `m_axis_tready` and the state; it has no dependence on `s_axis_tvalid`.
- `m_axis_tvalid`, once asserted, holds with stable data until `m_axis_tready` is sampled high.
- A rejected first beat needs output-register space to be accepted. This keeps classification on a single rule.
- Back-to-back packets with zero idle cycles are supported in all state orders.
- Reset values:
  - FSM = IDLE.
  - `m_axis_tvalid` = 0; `m_axis_tlast` = 0; `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tuser` = 0.
  - Counters = 0.
  - `s_axis_tready` = 1 in the first cycle after reset.
- Reset mid-packet: any partially forwarded packet is abandoned and the output register is cleared. The next ingress beat is treated as a first beat, so the upstream stage must be reset together with this block.

## Configuration
- `RMT_PKT_FILTER_STATS_EN` defined: `pass_cnt`, `drop_cnt` ports and their counter logic are present.
- Not defined: both ports and both counters are omitted. Forwarding behaviour is identical in both builds.

## Structure
- Shared package `rmt_filter_pkg` holds:
  - Field offset localparams: ETHERTYPE_LSB=128, IP_PROTO_LSB=216, MIN_HDR_BYTES=28.
  - The FSM state encoding (IDLE=0, FWD=1, DROP=2).
- One sub-module, `axis_out_reg`: the one-deep valid/ready output register. It takes a load strobe and exports its ready term.
- The classifier and FSM live in the top.

## Test plan
- UDP packet: 4 beats, first beat carries 16'h0008 and 8'h11, `m_axis_tready`=1 → 4 identical beats on `m_axis`, each one cycle delayed; tlast on the 4th beat; `pass_cnt`=1.
- TCP packet: same packet with proto 8'h06 → `m_axis_tvalid` stays 0; `s_axis_tready`=1 for all 4 beats; `drop_cnt`=1.
- Backpressure: `m_axis_tready` held low for 3 cycles during beat 2 of a UDP packet → `s_axis_tready` low during the stall; output is still 4 beats in order, with no loss or duplication.
- Mixed single-beat stream: single-beat UDP (tlast on first beat), then a TCP packet with zero gap, then a UDP packet → only packets 1 and 3 emerge; `pass_cnt`=2, `drop_cnt`=1.
- Runt: first beat matches on fields but tkeep=64'h0000_0000_00FF_FFFF → packet dropped; `drop_cnt`=1.
- Reset mid-packet: `areset` asserted one cycle after beat 2 → next cycle `m_axis_tvalid`=0 and counters=0; a following full UDP packet is forwarded correctly.

Source files
------------

// File: rtl/rmt_filter_pkg.sv
// Shared constants for the RMT ingress packet filter: first-beat field offsets
// and the classifier FSM state encoding.
package rmt_filter_pkg;

    localparam int ETHERTYPE_LSB = 128;
    localparam int IP_PROTO_LSB  = 216;
    localparam int MIN_HDR_BYTES = 28;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

endpackage

// File: rtl/rmt_pkt_filter_if.sv
// AXI-Stream bundle used on both sides of the RMT ingress packet filter.
interface rmt_pkt_filter_if #(
    parameter int DATA_W = 512,
    parameter int USER_W = 128
) ();

    localparam int KEEP_W = DATA_W / 8;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/axis_out_reg.sv
// One-deep valid/ready output register: refills on the same cycle it is popped,
// so a held-high tready sustains one beat per cycle.
module axis_out_reg #(
    parameter int DATA_W = 512,
    parameter int USER_W = 128
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  load,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [DATA_W/8-1:0]   in_keep,
    input  logic [USER_W-1:0]     in_user,
    input  logic                  in_last,
    output logic                  ready,
    rmt_pkt_filter_if.master      out
);

    // Space is available when empty or when the held beat leaves this cycle.
    assign ready = !out.tvalid || out.tready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    // NOTE: the payload flops are reset too, because downstream expects all-zero
    // outputs after reset; this costs reset fan-out but there is no memory array here.
    always_ff @(posedge clk) begin
        if (areset) begin
            out.tvalid <= 1'b0;
            out.tlast  <= 1'b0;
            out.tdata  <= '0;
            out.tkeep  <= '0;
            out.tuser  <= '0;
        end else if (load) begin
            out.tvalid <= 1'b1;
            out.tlast  <= in_last;
            out.tdata  <= in_data;
            out.tkeep  <= in_keep;
            out.tuser  <= in_user;
        end else if (out.tready) begin
            out.tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/rmt_pkt_filter.sv
// Ingress classifier ahead of rmt_wrapper: forwards VLAN-tagged IPv4/UDP packets
// unmodified and discards the rest. Define RMT_PKT_FILTER_STATS_EN for pass/drop counters.
module rmt_pkt_filter
    import rmt_filter_pkg::*;
#(
    parameter int          C_S_AXIS_DATA_WIDTH  = 512,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [15:0] ETHERTYPE_MATCH      = 16'h0008,
    parameter logic [7:0]  IP_PROTO_MATCH       = 8'h11,
    parameter int          CNT_WIDTH            = 32
) (
    input  logic               clk,
    input  logic               areset,
    rmt_pkt_filter_if.slave    s_axis,
    rmt_pkt_filter_if.master   m_axis
`ifdef RMT_PKT_FILTER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] pass_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
`endif
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       out_ready;
    logic       s_fire;
    logic       hdr_match;
    logic       load;

    // A runt (any of the first MIN_HDR_BYTES bytes missing) never matches.
    assign hdr_match = (s_axis.tdata[ETHERTYPE_LSB +: 16] == ETHERTYPE_MATCH)
                    && (s_axis.tdata[IP_PROTO_LSB +: 8] == IP_PROTO_MATCH)
                    && (&s_axis.tkeep[MIN_HDR_BYTES-1:0]);

    // Only a packet already known to be dropped may ignore output space.
    assign s_axis.tready = (state_q == ST_DROP) ? 1'b1 : out_ready;
    assign s_fire        = s_axis.tvalid && s_axis.tready;
    assign load          = s_fire && (((state_q == ST_IDLE) && hdr_match) || (state_q == ST_FWD));

    // NOTE: next-state defaults to the current state first, so no path through
    // the case leaves state_d unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (s_fire && !s_axis.tlast) state_d = hdr_match ? ST_FWD : ST_DROP;
            ST_FWD,
            ST_DROP: if (s_fire && s_axis.tlast) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    axis_out_reg #(
        .DATA_W (C_S_AXIS_DATA_WIDTH),
        .USER_W (C_S_AXIS_TUSER_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .areset  (areset),
        .load    (load),
        .in_data (s_axis.tdata),
        .in_keep (s_axis.tkeep),
        .in_user (s_axis.tuser),
        .in_last (s_axis.tlast),
        .ready   (out_ready),
        .out     (m_axis)
    );

`ifdef RMT_PKT_FILTER_STATS_EN
    // Counted on the first beat only; both wrap freely.
    always_ff @(posedge clk) begin
        if (areset) begin
            pass_cnt <= '0;
            drop_cnt <= '0;
        end else if (s_fire && (state_q == ST_IDLE)) begin
            if (hdr_match) pass_cnt <= pass_cnt + CNT_WIDTH'(1);
            else           drop_cnt <= drop_cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rmt_pkt_filter.sv
// Self-checking bench for rmt_pkt_filter: packet-level reference model with a
// per-cycle output compare, directed scenarios and a randomized packet stream.
module tb_rmt_pkt_filter;

    localparam int DW = 512;
    localparam int UW = 128;
    localparam int KW = 64;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    rmt_pkt_filter_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
    rmt_pkt_filter_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

`ifdef RMT_PKT_FILTER_STATS_EN
    logic [31:0] pass_cnt;
    logic [31:0] drop_cnt;
`endif

    rmt_pkt_filter dut (
        .clk    (clk),
        .areset (areset),
        .s_axis (s_if),
        .m_axis (m_if)
`ifdef RMT_PKT_FILTER_STATS_EN
        ,
        .pass_cnt (pass_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    beat_t exp_q[$];
    int    exp_cyc_q[$];
    int    rx_cnt = 0;
    int    exp_pass = 0;
    int    exp_drop = 0;
    bit    drop_phase = 1'b0;
    bit    strict_lat = 1'b0;
    int    mr_mode = 0;      // 0: tready high, 1: random, 2: driven by the test
    int    stall_waits = 0;

    always @(posedge clk) cyc++;

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference rule: VLAN-tagged IPv4 ethertype, UDP protocol, 28 header bytes present.
    function automatic bit model_match(beat_t b);
        return (b.data[143:128] == 16'h0008) && (b.data[223:216] == 8'h11)
            && (b.keep[27:0] == 28'hFFF_FFFF);
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // kind: 0 UDP, 1 TCP, 2 non-IPv4 ethertype, 3 runt UDP
    function automatic beat_t make_beat(int kind, int idx, int len);
        beat_t b;
        b.data = rand_data();
        b.user = {$urandom, $urandom, $urandom, $urandom};
        b.keep = {$urandom, $urandom};
        b.last = (idx == len - 1);
        if (idx == 0) begin
            b.keep = (kind == 3) ? 64'h0000_0000_00FF_FFFF : '1;
            b.data[143:128] = (kind == 2) ? 16'hDD86 : 16'h0008;
            b.data[223:216] = (kind == 1) ? 8'h06 : 8'h11;
        end
        return b;
    endfunction

    always @(posedge clk) begin
        #1;
        if (mr_mode == 0)      m_if.tready = 1'b1;
        else if (mr_mode == 1) m_if.tready = ($urandom_range(0, 3) != 0);
    end

    // Per-cycle compare of the egress stream and the ingress ready rule.
    beat_t prev_b;
    bit    stalled_prev = 1'b0;
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        int    ec;
        cur.data = m_if.tdata;
        cur.keep = m_if.tkeep;
        cur.user = m_if.tuser;
        cur.last = m_if.tlast;
        if (areset) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                check("hold_valid", m_if.tvalid, 1);
                check("hold_beat_stable", cur == prev_b, 1);
            end
            if (m_if.tvalid && m_if.tready) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h expected no beat", cur.data);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("out_tdata", cur.data, e.data);
                    check("out_tkeep", cur.keep, e.keep);
                    check("out_tuser", cur.user, e.user);
                    check("out_tlast", cur.last, e.last);
                    if (strict_lat) check("latency_cycle", cyc, ec);
                end
            end
            check("s_tready_rule", s_if.tready, drop_phase ? 1'b1 : (!m_if.tvalid || m_if.tready));
            stalled_prev = m_if.tvalid && !m_if.tready;
            prev_b = cur;
        end
    end

    task automatic send_beat(beat_t b, bit fwd, bit first);
        int waited = 0;
        bit rdy = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = b.data;
        s_if.tkeep  = b.keep;
        s_if.tuser  = b.user;
        s_if.tlast  = b.last;
        forever begin
            @(negedge clk);
            rdy = s_if.tready;
            @(posedge clk);
            if (rdy) break;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL ingress_timeout: got no transfer in %0d cycles expected transfer", waited);
                break;
            end
        end
        stall_waits += waited;
        #1;
        if (rdy) begin
            if (fwd) begin
                exp_q.push_back(b);
                exp_cyc_q.push_back(cyc);
            end
            if (first) begin
                if (fwd) exp_pass++;
                else     exp_drop++;
            end
            if (first && !fwd && !b.last) drop_phase = 1'b1;
            else if (b.last)              drop_phase = 1'b0;
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_pkt(int kind, int len, bit gaps);
        beat_t b;
        bit    fwd = 1'b0;
        for (int i = 0; i < len; i++) begin
            b = make_beat(kind, i, len);
            if (i == 0) fwd = model_match(b);
            send_beat(b, fwd, i == 0);
            if (gaps && ($urandom_range(0, 3) == 0))
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic check_stats(string tag, int p, int d);
`ifdef RMT_PKT_FILTER_STATS_EN
        check({tag, "_pass_cnt"}, pass_cnt, p);
        check({tag, "_drop_cnt"}, drop_cnt, d);
`endif
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin @(posedge clk); n++; end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        s_if.tvalid = 1'b0;
        drop_phase = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        exp_cyc_q.delete();
        exp_pass = 0;
        exp_drop = 0;
        @(negedge clk);
        check("rst_m_tvalid", m_if.tvalid, 0);
        check("rst_m_tlast", m_if.tlast, 0);
        check("rst_m_tdata", m_if.tdata, 0);
        check("rst_m_tkeep", m_if.tkeep, 0);
        check("rst_m_tuser", m_if.tuser, 0);
        check_stats("rst", 0, 0);
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        check("rst_s_tready", s_if.tready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int    base;
        beat_t b0;
        beat_t b2;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        check("model_udp_match", model_match(make_beat(0, 0, 4)), 1);
        check("model_tcp_match", model_match(make_beat(1, 0, 4)), 0);
        check("model_ethertype_match", model_match(make_beat(2, 0, 4)), 0);
        check("model_runt_match", model_match(make_beat(3, 0, 4)), 0);

        // 4-beat UDP packet, tready high
        strict_lat = 1'b1;
        base = rx_cnt;
        send_pkt(0, 4, 0);
        wait_drain();
        check("udp_beats", rx_cnt - base, 4);
        check_stats("udp", 1, 0);

        // 4-beat TCP packet: dropped without ever stalling ingress
        do_reset();
        base = rx_cnt;
        stall_waits = 0;
        send_pkt(1, 4, 0);
        wait_drain();
        check("tcp_beats", rx_cnt - base, 0);
        check("tcp_stall_waits", stall_waits, 0);
        check_stats("tcp", 0, 1);

        // Egress stall of 3 cycles during beat 2
        do_reset();
        strict_lat = 1'b0;
        mr_mode = 2;
        m_if.tready = 1'b1;
        base = rx_cnt;
        b0 = make_beat(0, 0, 4);
        send_beat(b0, model_match(b0), 1);
        send_beat(make_beat(0, 1, 4), 1, 0);
        m_if.tready = 1'b0;
        b2 = make_beat(0, 2, 4);
        s_if.tvalid = 1'b1;
        s_if.tdata  = b2.data;
        s_if.tkeep  = b2.keep;
        s_if.tuser  = b2.user;
        s_if.tlast  = b2.last;
        repeat (3) begin
            @(negedge clk);
            check("stall_s_tready", s_if.tready, 0);
            @(posedge clk);
            #1;
        end
        m_if.tready = 1'b1;
        send_beat(b2, 1, 0);
        send_beat(make_beat(0, 3, 4), 1, 0);
        mr_mode = 0;
        wait_drain();
        check("bp_beats", rx_cnt - base, 4);
        check_stats("bp", 1, 0);

        // Single-beat UDP, TCP, UDP back to back
        do_reset();
        strict_lat = 1'b1;
        base = rx_cnt;
        send_pkt(0, 1, 0);
        send_pkt(1, 3, 0);
        send_pkt(0, 2, 0);
        wait_drain();
        check("mixed_beats", rx_cnt - base, 3);
        check_stats("mixed", 2, 1);

        // Runt first beat
        do_reset();
        base = rx_cnt;
        send_pkt(3, 2, 0);
        wait_drain();
        check("runt_beats", rx_cnt - base, 0);
        check_stats("runt", 0, 1);

        // Reset one cycle after beat 2 of a UDP packet
        do_reset();
        b0 = make_beat(0, 0, 4);
        send_beat(b0, model_match(b0), 1);
        send_beat(make_beat(0, 1, 4), 1, 0);
        @(posedge clk);
        #1;
        areset = 1'b1;
        drop_phase = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_cyc_q.delete();
        exp_pass = 0;
        exp_drop = 0;
        @(negedge clk);
        check("midrst_m_tvalid", m_if.tvalid, 0);
        check_stats("midrst", 0, 0);
        @(posedge clk);
        #1;
        areset = 1'b0;
        base = rx_cnt;
        send_pkt(0, 4, 0);
        wait_drain();
        check("midrst_udp_beats", rx_cnt - base, 4);
        check_stats("midrst_udp", 1, 0);

        // Randomized stream with gaps and random egress backpressure
        do_reset();
        strict_lat = 1'b0;
        mr_mode = 1;
        for (int p = 0; p < 60; p++) send_pkt($urandom_range(0, 3), $urandom_range(1, 5), 1);
        mr_mode = 0;
        wait_drain();
        check_stats("rand", exp_pass, exp_drop);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
